obi_mgr_arbiter: RTL

Round-robin arbiter that shares one OBI subordinate port (`soc_pkg::sbr_obi_req_t` / `sbr_obi_rsp_t`) between `NumMgr` OBI managers. It sits between the managers (core instruction/data ports, debug, DMA) and the peripheral crossbar, which then decodes against `periph_addr_map`. An in-order ID FIFO records which manager owns each outstanding transaction so responses route back correctly. Address and response paths add zero cycles of latency.

---
 rtl/soc_pkg.sv | 30 +++
 rtl/obi_mgr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/soc_pkg.sv
// Shared SoC OBI subordinate-side request/response types.
package soc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
    logic            rready;
  } sbr_obi_req_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

// File: rtl/obi_mgr_arbiter.sv
// obi_mgr_arbiter: round-robin arbiter sharing one OBI subordinate port
// between NumMgr managers. An in-order ID FIFO (MaxTrans deep) records the
// owner of each outstanding transaction so responses route back to it.
// Address and response paths are purely combinational.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   mgr_req_i/o     per-manager OBI request in / response out
//   sbr_req_o/i     shared OBI request out / response in
//   busy_o          registered: outstanding count non-zero
//   spurious_rsp_o  registered pulse: rvalid seen with no outstanding txn
module obi_mgr_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 4,
  parameter int unsigned IdxW     = $clog2(NumMgr)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  sbr_obi_req_t [NumMgr-1:0] mgr_req_i,
  output sbr_obi_rsp_t [NumMgr-1:0] mgr_rsp_o,
  output sbr_obi_req_t              sbr_req_o,
  input  sbr_obi_rsp_t              sbr_rsp_i,
  output logic                      busy_o,
  output logic                      spurious_rsp_o
);

  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntMax  = cnt_t'(MaxTrans);
  localparam ptr_t PtrLast = ptr_t'(MaxTrans - 1);
  localparam idx_t IdxLast = idx_t'(NumMgr - 1);

  idx_t rr_q, rr_d;
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;
  idx_t fifo_q [MaxTrans];
  idx_t fifo_d [MaxTrans];
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  cnt_t cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic spurious_q, spurious_d;

  idx_t        sel;
  logic        found;
  int unsigned cand;
  logic        full;
  logic        nonempty;
  logic        req_fwd;
  logic        rready_fwd;
  idx_t        head;
  logic        push;
  logic        pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrLast) ? '0 : p + ptr_t'(1);
  endfunction

  // Manager selection: a held lock pins sel so a pending request is never
  // swapped out from under the subordinate.
  always_comb begin
    sel   = lock_idx_q;
    found = 1'b0;
    cand  = 0;
    if (!lock_q) begin
      sel = rr_q;
      for (int unsigned i = 0; i < NumMgr; i++) begin
        cand = (32'(rr_q) + i) % NumMgr;
        if (!found && mgr_req_i[idx_t'(cand)].req) begin
          sel   = idx_t'(cand);
          found = 1'b1;
        end
      end
    end
  end

  assign full     = (cnt_q == CntMax);
  assign nonempty = (cnt_q != '0);
  assign head     = fifo_q[rptr_q];

  // Reset gating keeps the forwarded request low while rst_i is held even
  // if managers are requesting.
  assign req_fwd    = mgr_req_i[sel].req && !full && !rst_i;
  assign rready_fwd = nonempty ? mgr_req_i[head].rready : 1'b1;
  assign push       = req_fwd && sbr_rsp_i.gnt;
  assign pop        = sbr_rsp_i.rvalid && rready_fwd && nonempty;

  always_comb begin
    sbr_req_o        = '0;
    sbr_req_o.req    = req_fwd;
    sbr_req_o.a      = mgr_req_i[sel].req ? mgr_req_i[sel].a : '0;
    sbr_req_o.rready = rready_fwd;
  end

  always_comb begin
    mgr_rsp_o          = '0;
    mgr_rsp_o[sel].gnt = push;
    if (nonempty) begin
      mgr_rsp_o[head].rvalid = sbr_rsp_i.rvalid;
      mgr_rsp_o[head].r      = sbr_rsp_i.r;
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;

    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = ptr_inc(wptr_q);
      rr_d           = (sel == IdxLast) ? '0 : sel + idx_t'(1);
      lock_d         = 1'b0;
    end else if (req_fwd) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end

    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase

    busy_d     = (cnt_d != '0);
    spurious_d = sbr_rsp_i.rvalid && !nonempty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int unsigned i = 0; i < MaxTrans; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      spurious_q <= spurious_d;
    end
  end

  assign busy_o         = busy_q;
  assign spurious_rsp_o = spurious_q;

endmodule
